// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, defaults and entry layout for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int INST_W        = 32;
    localparam int IMEM_AW       = 5;
    localparam int ENTRY_W       = 2 * INST_W;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Queue entry: upper half is the PC, lower half the big-endian word.
    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] word;
    } fetch_entry_t;

    // Byte address of byte idx within the word at pc; wraps inside the 32-byte memory.
    function automatic logic [IMEM_AW-1:0] byte_addr(input logic [INST_W-1:0] pc,
                                                     input logic [1:0] idx);
        return pc[IMEM_AW-1:0] + {{(IMEM_AW-2){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: circular queue of {pc,word} entries with push, pop, flush and count.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_entry,
    output logic [ENTRY_W-1:0] head_entry,
    output logic [3:0]         count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [3:0]       DEPTH_CNT = 4'(DEPTH);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [3:0]         count_r;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Qualify requests so a stray pop on empty or push on full cannot corrupt state.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && (count_r != 4'd0)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && ((count_r < DEPTH_CNT) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy; flush only empties, reset also clears entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= 4'd0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_entry = mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/inst_fetch_queue.sv
// Byte-serial instruction fetcher: assembles big-endian words from a 32-byte
// memory one byte per cycle and queues them with their PC for the processor.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [7:0]          imem_data,
    input  logic                redirect,
    input  logic [INST_W-1:0]   redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst_out,
    output logic [INST_W-1:0]   inst_pc,
    output logic [3:0]          count
);

    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    logic [INST_W-1:0]  fetch_pc_r;
    logic [1:0]         byte_idx_r;
    logic [23:0]        partial_r;
    logic [3:0]         fifo_count_s;
    logic [ENTRY_W-1:0] head_s;
    logic [ENTRY_W-1:0] push_entry_s;
    fetch_entry_t       head_fields_s;
    logic               pop_s;
    logic               push_s;
    logic               capture_s;

    // Handshake decode; only the final byte stalls, and only when no slot frees this edge.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        capture_s    = 1'b1;
        push_entry_s = {fetch_pc_r, partial_r, imem_data};
        if ((fifo_count_s != 4'd0) && inst_ready && !redirect) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if ((byte_idx_r == 2'd3) && (fifo_count_s == DEPTH_CNT) && !pop_s) begin
            capture_s = 1'b0;
        end else begin
            capture_s = 1'b1;
        end
        if (capture_s && (byte_idx_r == 2'd3) && !redirect) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Byte assembler; reset beats redirect, which beats normal capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            byte_idx_r <= 2'd0;
            partial_r  <= 24'd0;
        end else if (redirect) begin
            fetch_pc_r <= {redirect_pc[INST_W-1:2], 2'b00};
            byte_idx_r <= 2'd0;
            partial_r  <= 24'd0;
        end else if (capture_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
                2'd0:    partial_r[23:16] <= imem_data;
                2'd1:    partial_r[15:8]  <= imem_data;
                2'd2:    partial_r[7:0]   <= imem_data;
                2'd3:    fetch_pc_r       <= fetch_pc_r + 32'd4;
                default: partial_r        <= partial_r;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect),
        .push_entry(push_entry_s),
        .head_entry(head_s),
        .count     (fifo_count_s)
    );

    assign head_fields_s = fetch_entry_t'(head_s);
    assign imem_addr     = byte_addr(fetch_pc_r, byte_idx_r);
    assign inst_valid    = (fifo_count_s != 4'd0);
    assign inst_out      = head_fields_s.word;
    assign inst_pc       = head_fields_s.pc;
    assign count         = fifo_count_s;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench: expected program-order instruction stream is queued whenever
// the fetch start point changes; a negedge monitor pops it on every transfer.
module tb_inst_fetch_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  imem_addr;
    logic [7:0]  imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [3:0]  count;

    logic [7:0]  imem [32];
    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          transfers = 0;
    bit          mon_en = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_out;
    logic [31:0] prev_pc;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Big-endian word at pc, addresses wrapping inside the 32-byte memory.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] a;
            a = pc[4:0] + 5'(i);
            w[31-8*i -: 8] = imem[a];
        end
        return w;
    endfunction

    // Restart the expected stream: instructions in program order from start.
    task automatic fill(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back('{pc: pc, word: word_at(pc)});
            pc = pc + 32'd4;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: protocol invariants plus in-order comparison of every transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("valid_eq_count_nz", {31'd0, inst_valid}, {31'd0, (count != 4'd0)});
            chk("count_le_depth", {31'd0, (count <= 4'd4)}, 32'd1);
            if (hold_prev) begin
                chk("stall_out_stable", inst_out, prev_out);
                chk("stall_pc_stable", inst_pc, prev_pc);
            end
            hold_prev = inst_valid && !inst_ready && !redirect && !reset;
            prev_out  = inst_out;
            prev_pc   = inst_pc;
            if (!reset && !redirect && inst_valid && inst_ready) begin
                transfers++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got pc %h, nothing expected", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", inst_pc, e.pc);
                    chk("xfer_word", inst_out, e.word);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc0;
        int r;
        for (int i = 0; i < 32; i++) imem[i] = 8'($urandom);
        imem[0] = 8'h8C; imem[1] = 8'h22; imem[2] = 8'h00; imem[3] = 8'h04;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b1;
        fill(32'h0);
        step(2);
        mon_en = 1'b1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_out", inst_out, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_addr", {27'd0, imem_addr}, 32'd0);

        // First word latency: bytes on E1..E4, valid only after E4.
        reset = 1'b0;
        step(3);
        chk("e3_not_valid", {31'd0, inst_valid}, 32'd0);
        step(1);
        chk("e4_valid", {31'd0, inst_valid}, 32'd1);
        chk("e4_out", inst_out, 32'h8C22_0004);
        chk("e4_pc", inst_pc, 32'd0);

        // Back-pressure: queue saturates and fetch parks on byte 3 of the fifth word.
        inst_ready = 1'b0;
        step(40);
        chk("full_count", {28'd0, count}, 32'd4);
        chk("full_addr", {27'd0, imem_addr}, 32'h13);
        inst_ready = 1'b1;
        pc0 = inst_pc;
        step(1);
        chk("pushpop_full_count", {28'd0, count}, 32'd4);
        chk("pushpop_full_pc", inst_pc, pc0 + 32'd4);

        // Redirect with two entries queued.
        inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0; fill(32'h0);
        step(1);
        redirect = 1'b0;
        step(8);
        chk("two_queued", {28'd0, count}, 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_000E; fill(32'h0000_000C);
        step(1);
        redirect = 1'b0;
        chk("redir_count", {28'd0, count}, 32'd0);
        chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_addr", {27'd0, imem_addr}, 32'h0C);
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && !inst_valid; i++) step(1);
        chk("redir_first_pc", inst_pc, 32'h0000_000C);

        // Address wrap from the top of memory.
        redirect = 1'b1; redirect_pc = 32'h0000_001C; fill(32'h0000_001C);
        step(1);
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", {27'd0, imem_addr}, 32'h1C + 32'(i));
            step(1);
        end
        chk("wrap_addr_0", {27'd0, imem_addr}, 32'h00);

        // Reset after byte 2 of a word discards it and restarts at RESET_PC.
        redirect = 1'b1; redirect_pc = 32'h0000_0008; fill(32'h8);
        step(1);
        redirect = 1'b0;
        step(3);
        reset = 1'b1; fill(32'h0);
        step(1);
        reset = 1'b0;
        chk("mid_rst_count", {28'd0, count}, 32'd0);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_out", inst_out, 32'd0);
        chk("mid_rst_pc", inst_pc, 32'd0);
        chk("mid_rst_addr", {27'd0, imem_addr}, 32'd0);
        step(4);
        chk("refetch_valid", {31'd0, inst_valid}, 32'd1);
        chk("refetch_pc", inst_pc, 32'd0);
        chk("refetch_out", inst_out, 32'h8C22_0004);

        // Random traffic: ready jitter, redirects anywhere, occasional reset.
        transfers = 0;
        for (int c = 0; c < 2000; c++) begin
            inst_ready = ($urandom_range(9) < 7);
            r = $urandom_range(99);
            reset = 1'b0; redirect = 1'b0;
            if (r < 1) begin
                reset = 1'b1;
                redirect = 1'($urandom_range(1));
                redirect_pc = $urandom;
                fill(32'h0);
            end else if (r < 6) begin
                redirect = 1'b1;
                redirect_pc = $urandom;
                fill({redirect_pc[31:2], 2'b00});
            end
            step(1);
        end
        reset = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
        step(10);
        chk("random_progress", {31'd0, (transfers > 300)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
